// File: rtl/ethpipe_tx_pkg.sv
// Shared definitions for the Ethernet TX frame loader.
//   HDR_WORDS : words ahead of the payload in a slot (length + timestamp + hash)
//   SLOT_AW   : TX slot RAM word address width
//   addr_t    : slot word address / pointer type (arithmetic wraps naturally)
//   tx_state_e: frame loader FSM states
package ethpipe_tx_pkg;

  localparam int unsigned HDR_WORDS = 7;
  localparam int unsigned SLOT_AW   = 14;

  typedef logic [SLOT_AW-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    PAD,
    LEN,
    COMMIT,
    DROP
  } tx_state_e;

endpackage

// File: rtl/tx_frame_loader_if.sv
// Signal bundle for the TX frame loader: input byte stream with per-frame
// metadata, TX slot RAM write port, ring pointers and status.
//   master : stream producer / RAM consumer side
//   slave  : frame loader side
interface tx_frame_loader_if;
  import ethpipe_tx_pkg::*;

  logic        in_valid;
  logic        in_last;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [63:0] in_timestamp;
  logic [31:0] in_hash;
  logic [15:0] slot_tx_eth_data;
  logic [1:0]  slot_tx_eth_byte_en;
  addr_t       slot_tx_eth_addr;
  logic        slot_tx_eth_wr_en;
  addr_t       mem_rd_ptr;
  addr_t       mem_wr_ptr;
  logic        err_oversize;
  logic [31:0] frames_committed;

  modport master (
    output in_valid, in_last, in_data, in_timestamp, in_hash, mem_rd_ptr,
    input  in_ready, slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr,
           slot_tx_eth_wr_en, mem_wr_ptr, err_oversize, frames_committed
  );

  modport slave (
    input  in_valid, in_last, in_data, in_timestamp, in_hash, mem_rd_ptr,
    output in_ready, slot_tx_eth_data, slot_tx_eth_byte_en, slot_tx_eth_addr,
           slot_tx_eth_wr_en, mem_wr_ptr, err_oversize, frames_committed
  );

endinterface

// File: rtl/tx_frame_loader.sv
// TX frame loader: packs an incoming byte stream into the TX slot RAM ring.
// Slot layout at base: word0 = padded length + 1, words 1-4 timestamp (MSW
// first), words 5-6 hash (MSW first), then payload two bytes per word with
// the earlier byte high. mem_wr_ptr only moves once a whole slot is written.
// Ports:
//   gmii_tx_clk, sys_rst_n            : clock, async active-low reset
//   in_valid/in_last/in_data/in_ready : byte stream handshake
//   in_timestamp, in_hash             : per-frame metadata, valid with byte 0
//   slot_tx_eth_*                     : registered RAM write port
//   mem_rd_ptr / mem_wr_ptr           : consumer / committed producer pointer
//   err_oversize, frames_committed    : drop pulse, committed frame count
module tx_frame_loader
  import ethpipe_tx_pkg::*;
#(
  parameter int unsigned MIN_LEN = 60,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic [63:0] in_timestamp,
  input  logic [31:0] in_hash,
  output logic [15:0] slot_tx_eth_data,
  output logic [1:0]  slot_tx_eth_byte_en,
  output logic [13:0] slot_tx_eth_addr,
  output logic        slot_tx_eth_wr_en,
  input  logic [13:0] mem_rd_ptr,
  output logic [13:0] mem_wr_ptr,
  output logic        err_oversize,
  output logic [31:0] frames_committed
);

  localparam logic [15:0] LP_MIN = 16'(MIN_LEN);
  localparam logic [15:0] LP_MAX = 16'(MAX_LEN);
  localparam addr_t       LP_HDR = addr_t'(HDR_WORDS);

  tx_state_e   r_state, w_state_nxt;
  logic [63:0] r_ts;
  logic [31:0] r_hash;
  addr_t       r_base, r_addr, r_end, r_wr_ptr;
  logic [2:0]  r_hdr_idx;
  logic [15:0] r_cnt, r_len;
  logic [7:0]  r_hi;
  logic [31:0] r_frames;
  logic        r_err;
  logic        r_slot_we;
  logic [1:0]  r_slot_be;
  addr_t       r_slot_addr;
  logic [15:0] r_slot_data;

  logic        w_ready, w_we, w_acc, w_drop, w_full;
  addr_t       w_waddr, w_end;
  logic [15:0] w_wdata, w_cnt_nxt, w_len;

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_acc       = 1'b0;
    w_drop      = 1'b0;
    w_waddr     = (r_state == LEN) ? r_base : r_addr;
    // Ring full: writing here would catch up with the consumer.
    w_full      = (w_waddr + addr_t'(1)) == mem_rd_ptr;
    w_cnt_nxt   = r_cnt + 16'd1;
    w_len       = (w_cnt_nxt < LP_MIN) ? LP_MIN : w_cnt_nxt;
    w_end       = r_base + LP_HDR + addr_t'((w_len + 16'd1) >> 1);

    case (r_state)
      IDLE: if (in_valid) w_state_nxt = HDR;
      HDR: begin
        if (!w_full) begin
          w_we = 1'b1;
          case (r_hdr_idx)
            3'd1:    w_wdata = r_ts[63:48];
            3'd2:    w_wdata = r_ts[47:32];
            3'd3:    w_wdata = r_ts[31:16];
            3'd4:    w_wdata = r_ts[15:0];
            3'd5:    w_wdata = r_hash[31:16];
            default: w_wdata = r_hash[15:0];
          endcase
          if (r_hdr_idx == 3'd6) w_state_nxt = DATA;
        end
      end
      DATA: begin
        // Stall on full regardless of byte parity so the check stays per-address.
        w_ready = !w_full;
        w_acc   = in_valid && w_ready;
        if (w_acc) begin
          if (w_cnt_nxt > LP_MAX) begin
            w_drop      = 1'b1;
            w_state_nxt = in_last ? IDLE : DROP;
          end else begin
            if (r_cnt[0]) begin
              w_we    = 1'b1;
              w_wdata = {r_hi, in_data};
            end else if (in_last) begin
              w_we    = 1'b1;
              w_wdata = {in_data, 8'h00};
            end
            if (in_last) w_state_nxt = (w_cnt_nxt < LP_MIN) ? PAD : LEN;
          end
        end
      end
      PAD: begin
        // An odd last byte already supplied one pad byte in its word.
        if (r_addr == r_end) w_state_nxt = LEN;
        else if (!w_full) w_we = 1'b1;
      end
      LEN: begin
        if (!w_full) begin
          w_we        = 1'b1;
          w_wdata     = r_len + 16'd1;
          w_state_nxt = COMMIT;
        end
      end
      COMMIT: w_state_nxt = IDLE;
      DROP: begin
        w_ready = 1'b1;
        if (in_valid && in_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_ts        <= '0;
      r_hash      <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_end       <= '0;
      r_wr_ptr    <= '0;
      r_hdr_idx   <= '0;
      r_cnt       <= '0;
      r_len       <= '0;
      r_hi        <= '0;
      r_frames    <= '0;
      r_err       <= 1'b0;
      r_slot_we   <= 1'b0;
      r_slot_be   <= '0;
      r_slot_addr <= '0;
      r_slot_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_err       <= w_drop;
      r_slot_we   <= w_we;
      r_slot_be   <= w_we ? 2'b11 : 2'b00;
      r_slot_addr <= w_waddr;
      r_slot_data <= w_wdata;
      // r_addr keeps the slot end through LEN so COMMIT can publish it.
      if (w_we && r_state != LEN) r_addr <= r_addr + addr_t'(1);
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_ts      <= in_timestamp;
            r_hash    <= in_hash;
            r_base    <= r_wr_ptr;
            r_addr    <= r_wr_ptr + addr_t'(1);
            r_hdr_idx <= 3'd1;
            r_cnt     <= '0;
          end
        end
        HDR: if (w_we) r_hdr_idx <= r_hdr_idx + 3'd1;
        DATA: begin
          if (w_acc && !w_drop) begin
            r_cnt <= w_cnt_nxt;
            r_hi  <= in_data;
            if (in_last) begin
              r_len <= w_len;
              r_end <= w_end;
            end
          end
        end
        COMMIT: begin
          r_wr_ptr <= r_addr;
          r_frames <= r_frames + 32'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready            = w_ready;
  assign slot_tx_eth_wr_en   = r_slot_we;
  assign slot_tx_eth_byte_en = r_slot_be;
  assign slot_tx_eth_addr    = r_slot_addr;
  assign slot_tx_eth_data    = r_slot_data;
  assign mem_wr_ptr          = r_wr_ptr;
  assign err_oversize        = r_err;
  assign frames_committed    = r_frames;

endmodule

// File: tb/tb_tx_frame_loader.sv
// Bench for tx_frame_loader: expected slot writes are derived from each
// frame's byte list and queued; a monitor pops and compares every RAM write.
module tb_tx_frame_loader;
  import ethpipe_tx_pkg::*;

  localparam int unsigned MIN_LEN = 60;
  localparam int unsigned MAX_LEN = 1518;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    addr_t       addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_frame_loader_if bus ();

  tx_frame_loader #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN)) dut (
    .gmii_tx_clk        (clk),
    .sys_rst_n          (rst_n),
    .in_valid           (bus.in_valid),
    .in_last            (bus.in_last),
    .in_data            (bus.in_data),
    .in_ready           (bus.in_ready),
    .in_timestamp       (bus.in_timestamp),
    .in_hash            (bus.in_hash),
    .slot_tx_eth_data   (bus.slot_tx_eth_data),
    .slot_tx_eth_byte_en(bus.slot_tx_eth_byte_en),
    .slot_tx_eth_addr   (bus.slot_tx_eth_addr),
    .slot_tx_eth_wr_en  (bus.slot_tx_eth_wr_en),
    .mem_rd_ptr         (bus.mem_rd_ptr),
    .mem_wr_ptr         (bus.mem_wr_ptr),
    .err_oversize       (bus.err_oversize),
    .frames_committed   (bus.frames_committed)
  );

  wr_t         sb_q[$];
  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          skip_wr = 1'b0;
  int unsigned err_pulses = 0;
  addr_t       last_wr_addr = '0;
  addr_t       exp_wr_ptr = '0;
  logic [31:0] exp_frames = '0;
  int unsigned acc_count = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic bq_t make_frame(input int unsigned n);
    bq_t q;
    for (int unsigned i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Monitor: every RAM write is compared against the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.err_oversize) err_pulses++;
        if (bus.slot_tx_eth_wr_en) begin
          last_wr_addr = bus.slot_tx_eth_addr;
          if (!skip_wr) begin
            if (sb_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected write: addr %0d data %0h, none expected",
                       bus.slot_tx_eth_addr, bus.slot_tx_eth_data);
            end else begin
              wr_t e;
              e = sb_q.pop_front();
              check("ram write {be,addr,data}",
                    {bus.slot_tx_eth_byte_en, bus.slot_tx_eth_addr, bus.slot_tx_eth_data},
                    {2'b11, e.addr, e.data});
            end
          end
        end
      end
    end
  end

  // Reference slot image: header, payload zero-padded to MIN_LEN and to a
  // whole word, then the length word at base last.
  task automatic push_exp(input bq_t d, input logic [63:0] ts, input logic [31:0] h);
    addr_t       base;
    int unsigned n;
    logic [95:0] meta;
    logic [7:0]  hi, lo;
    base = exp_wr_ptr;
    n    = (d.size() < MIN_LEN) ? MIN_LEN : d.size();
    meta = {ts, h};
    for (int unsigned k = 0; k < 6; k++)
      sb_q.push_back('{addr: base + addr_t'(1 + k), data: meta[95 - 16*k -: 16]});
    for (int unsigned i = 0; i < n; i += 2) begin
      hi = (i < d.size()) ? d[i] : 8'h00;
      lo = (i + 1 < d.size()) ? d[i+1] : 8'h00;
      sb_q.push_back('{addr: base + addr_t'(7 + i/2), data: {hi, lo}});
    end
    sb_q.push_back('{addr: base, data: 16'(n + 1)});
    exp_wr_ptr = base + addr_t'(7 + (n + 1) / 2);
  endtask

  task automatic drive_frame(input bq_t d, input logic [63:0] ts, input logic [31:0] h,
                             input int unsigned gap_max, output bit ok);
    int unsigned gap, w;
    bit acc;
    ok = 1'b1;
    acc_count = 0;
    bus.in_timestamp = ts;
    bus.in_hash = h;
    for (int unsigned i = 0; i < d.size(); i++) begin
      gap = (i == 0 || gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
      bus.in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = d[i];
      bus.in_last  = (i == d.size() - 1);
      acc = 1'b0;
      w   = 0;
      while (!acc && w < 1000) begin
        #8;
        acc = bus.in_ready;
        @(posedge clk); #1;
        w++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL byte accept timeout: byte %0d not accepted, required within 1000 cycles", i);
        ok = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_last = 1'b0;
        return;
      end
      acc_count++;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_commit(input string name);
    int unsigned w;
    w = 0;
    while (bus.frames_committed == exp_frames && w < 200) begin @(posedge clk); #1; w++; end
    exp_frames++;
    check({name, " frames_committed"}, bus.frames_committed, exp_frames);
    check({name, " mem_wr_ptr"}, bus.mem_wr_ptr, exp_wr_ptr);
    check({name, " pending writes"}, sb_q.size(), 0);
  endtask

  task automatic run_frame(input bq_t d, input logic [63:0] ts, input logic [31:0] h,
                           input int unsigned gap_max, input string name);
    bit ok;
    bus.mem_rd_ptr = exp_wr_ptr;
    push_exp(d, ts, h);
    drive_frame(d, ts, h, gap_max, ok);
    if (ok) wait_commit(name);
    else sb_q.delete();
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t         d;
    bit          ok;
    addr_t       b;
    int unsigned rem, a, err0;

    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    bus.in_data = '0;
    bus.in_timestamp = '0;
    bus.in_hash = '0;
    bus.mem_rd_ptr = '0;
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("reset in_ready", bus.in_ready, 0);
    check("reset mem_wr_ptr", bus.mem_wr_ptr, 0);
    check("reset frames_committed", bus.frames_committed, 0);
    check("reset err_oversize", bus.err_oversize, 0);
    check("reset slot port", {bus.slot_tx_eth_wr_en, bus.slot_tx_eth_byte_en,
                               bus.slot_tx_eth_addr, bus.slot_tx_eth_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed lengths: even, odd, short/padded, single byte, pad boundaries.
    d = make_frame(64); run_frame(d, 64'h0102030405060708, 32'hAABBCCDD, 0, "len64");
    check("len64 advance", bus.mem_wr_ptr, 39);
    d = make_frame(61); run_frame(d, {$urandom, $urandom}, $urandom, 0, "len61");
    check("len61 advance", bus.mem_wr_ptr, 39 + 38);
    d = make_frame(10); run_frame(d, {$urandom, $urandom}, $urandom, 2, "len10");
    check("len10 advance", bus.mem_wr_ptr, 39 + 38 + 37);
    d = make_frame(1);  run_frame(d, {$urandom, $urandom}, $urandom, 0, "len1");
    d = make_frame(59); run_frame(d, {$urandom, $urandom}, $urandom, 1, "len59");
    d = make_frame(60); run_frame(d, {$urandom, $urandom}, $urandom, 1, "len60");

    for (int unsigned f = 0; f < 20; f++) begin
      d = make_frame($urandom_range(130, 1));
      run_frame(d, {$urandom, $urandom}, $urandom, 3, "random");
    end

    // Oversize: every byte consumed, one drop pulse, nothing committed.
    err0 = err_pulses;
    skip_wr = 1'b1;
    bus.mem_rd_ptr = exp_wr_ptr;
    d = make_frame(MAX_LEN + 1);
    drive_frame(d, {$urandom, $urandom}, $urandom, 1, ok);
    check("oversize bytes consumed", acc_count, MAX_LEN + 1);
    repeat (10) begin @(posedge clk); #1; end
    skip_wr = 1'b0;
    check("oversize mem_wr_ptr", bus.mem_wr_ptr, exp_wr_ptr);
    check("oversize frames_committed", bus.frames_committed, exp_frames);
    check("oversize err pulses", err_pulses - err0, 1);
    d = make_frame(64); run_frame(d, {$urandom, $urandom}, $urandom, 0, "after drop");

    // Ring-full stall: consumer parked at base+20.
    d = make_frame(64);
    b = exp_wr_ptr;
    push_exp(d, 64'h1122334455667788, 32'h01020304);
    bus.mem_rd_ptr = b + addr_t'(20);
    acc_count = 0;
    fork
      drive_frame(d, 64'h1122334455667788, 32'h01020304, 0, ok);
      begin
        int unsigned w;
        w = 0;
        while (acc_count < 24 && w < 500) begin @(posedge clk); #1; w++; end
        repeat (20) begin @(posedge clk); #1; end
        check("stall bytes accepted", acc_count, 24);
        check("stall in_ready", bus.in_ready, 0);
        check("stall last write addr", last_wr_addr, b + addr_t'(18));
        bus.mem_rd_ptr = b;
      end
    join
    if (ok) wait_commit("stall");
    else sb_q.delete();
    @(posedge clk); #1;

    // Fill the ring up to 16380, then a frame that wraps the address space.
    rem = 16380 - 32'(exp_wr_ptr);
    while (rem != 0) begin
      a = rem;
      if (a > 766) a = (rem - 766 >= 37) ? 766 : rem - 37;
      d = make_frame(2 * (a - 7));
      run_frame(d, {$urandom, $urandom}, $urandom, 0, "fill");
      rem -= a;
    end
    check("pre-wrap mem_wr_ptr", bus.mem_wr_ptr, 16380);
    d = make_frame(64); run_frame(d, 64'h0102030405060708, 32'hAABBCCDD, 0, "wrap");
    check("wrap commit value", bus.mem_wr_ptr, 35);

    // Reset in the middle of a frame discards it.
    skip_wr = 1'b1;
    bus.mem_rd_ptr = exp_wr_ptr;
    bus.in_valid = 1'b1;
    bus.in_last = 1'b0;
    repeat (20) begin bus.in_data = 8'($urandom); @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid-frame reset mem_wr_ptr", bus.mem_wr_ptr, 0);
    check("mid-frame reset frames", bus.frames_committed, 0);
    check("mid-frame reset in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    sb_q.delete();
    skip_wr = 1'b0;
    exp_wr_ptr = '0;
    exp_frames = '0;
    @(posedge clk); #1;
    d = make_frame(20); run_frame(d, {$urandom, $urandom}, $urandom, 1, "post reset");

    check("total err pulses", err_pulses, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_frame_loader.md
TX_FRAME_LOADER -- requirements
Module: tx_frame_loader

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60: minimum frame byte count, excluding FCS; shorter frames are zero-padded.
REQ-002 SHALL have parameter MAX_LEN, default 1518: maximum accepted frame byte count, excluding FCS.
REQ-003 SHALL have port gmii_tx_clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid, in_last, input, 1 bit each: byte-stream valid and last-byte-of-frame flags.
REQ-006 SHALL have port in_data, input, 8 bits: frame byte, destination MAC first, no preamble or FCS.
REQ-007 SHALL have port in_ready, output, 1 bit: a byte is accepted when in_valid and in_ready are both high.
REQ-008 SHALL have ports in_timestamp (64 bits) and in_hash (32 bits), input: per-frame metadata, valid with the first byte.
REQ-009 SHALL have ports slot_tx_eth_data (16 bits), slot_tx_eth_byte_en (2 bits), slot_tx_eth_addr (14 bits) and slot_tx_eth_wr_en (1 bit), all outputs: TX slot RAM write port.
REQ-010 SHALL have port mem_rd_ptr, input, 14 bits: consumer word read pointer.
REQ-011 SHALL have port mem_wr_ptr, output, 14 bits: committed word write pointer.
REQ-012 SHALL have ports err_oversize (1 bit, output): one-cycle drop pulse; and frames_committed (32 bits, output): count of committed frames.

Function
REQ-013 SHALL write each frame at base = mem_wr_ptr in this layout:
- word0 = N+1, where N = padded byte count
- words 1-4 = timestamp[63:0], MSW first
- words 5-6 = hash[31:0], MSW first
- word 7 onward: data, two bytes per word, earlier byte in [15:8]
REQ-014 SHALL use states IDLE, HDR, DATA, PAD, LEN, COMMIT, DROP.
REQ-015 In IDLE with in_valid high, SHALL latch in_timestamp and in_hash with in_ready low, then go to HDR.
REQ-016 In HDR, SHALL write words base+1..base+6 in 6 cycles with in_ready low, then go to DATA.
REQ-017 In DATA, SHALL accept one byte per cycle and write one word per two bytes, with byte_en 2'b11.
REQ-018 If the byte count is odd at in_last, SHALL write the final word as {byte, 8'h00}.
REQ-019 If N < MIN_LEN at in_last, SHALL go to PAD and write zero bytes until N = MIN_LEN.
REQ-020 SHALL write word0 at base in LEN.
REQ-021 In COMMIT, SHALL set mem_wr_ptr <= base + 7 + ceil(N/2), increment frames_committed, and return to IDLE.
REQ-022 SHALL perform all pointer and address arithmetic modulo 2^14.
REQ-023 SHALL treat the RAM as full when (write address + 1) == mem_rd_ptr; when full, no write and in_ready low, with the stall applying in every writing state.
REQ-024 SHALL, when byte count exceeds MAX_LEN, pulse err_oversize, go to DROP, and hold in_ready high until in_last is accepted.
REQ-025 After a drop, SHALL leave mem_wr_ptr unchanged and go to IDLE.
REQ-026 SHALL never change mem_wr_ptr except in COMMIT, so partial frames are never visible.
REQ-027 SHALL treat in_last on the first byte as a 1-byte frame, padded to MIN_LEN.

Reset
REQ-028 On sys_rst_n low, SHALL asynchronously set the state to IDLE and set mem_wr_ptr, frames_committed, slot_tx_eth_* outputs, in_ready and err_oversize to 0.
REQ-029 SHALL discard any frame in progress at reset; mem_wr_ptr stays 0.

Structure
REQ-030 SHALL place the state encoding, header word count (7) and slot address width (14) in a shared package, ethpipe_tx_pkg.
REQ-031 SHALL be a single module with no sub-modules.

Verification
REQ-032 SHALL cover a 64-byte frame with ts=64'h0102030405060708 and hash=32'hAABBCCDD -> word0=65, words 1-6 as specified, mem_wr_ptr 0->39.
REQ-033 SHALL cover a 61-byte frame -> last word {byte61, 8'h00}, word0=62, mem_wr_ptr advances by 38.
REQ-034 SHALL cover a 10-byte frame -> 50 zero pad bytes, word0=61, advance 37.
REQ-035 SHALL cover a 1519-byte frame -> err_oversize one pulse, all bytes consumed, mem_wr_ptr and frames_committed unchanged.
REQ-036 SHALL cover mem_wr_ptr=16380 with mem_rd_ptr=16380 and a 64-byte frame -> addresses wrap to 0, commit value 35.
REQ-037 SHALL cover mem_rd_ptr = base+20 held static -> in_ready stalls after the word at base+18; releasing mem_rd_ptr resumes the write with no data loss.
